// File: rtl/mux_pkg.sv
// Shared select encodings and widths for the 4:1 word selector.
package mux_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_IN0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_IN1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_IN2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_IN3 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux4x1_comb.sv
// Purely combinational 4:1 word select; the default arm keeps X off the output
// when sel is unknown.
module mux4x1_comb
  import mux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in0,
  input  logic [N-1:0]     in1,
  input  logic [N-1:0]     in2,
  input  logic [N-1:0]     in3,
  output logic [N-1:0]     word_c
);

  always_comb begin
    word_c = in0;
    case (sel)
      SEL_IN0: word_c = in0;
      SEL_IN1: word_c = in1;
      SEL_IN2: word_c = in2;
      SEL_IN3: word_c = in3;
      default: word_c = in0;
    endcase
  end

endmodule : mux4x1_comb

// File: rtl/mux4x1_param.sv
// Registered 4:1 word selector: the selected word is loaded on en and appears
// one clock later; out_vld is sticky until reset.
module mux4x1_param
  import mux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in0,
  input  logic [N-1:0]     in1,
  input  logic [N-1:0]     in2,
  input  logic [N-1:0]     in3,
  output logic [N-1:0]     out,
  output logic             out_vld
);

  logic [N-1:0] word_c;

  mux4x1_comb #(.N(N)) u_sel (
    .sel    (sel),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .word_c (word_c)
  );

  // Output register; reset wins over a simultaneous capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= '0;
      out_vld <= 1'b0;
    end else if (en) begin
      out     <= word_c;
      out_vld <= 1'b1;
    end
  end

endmodule : mux4x1_param

// File: tb/tb_mux4x1_param.sv
// Directed bench for mux4x1_param at N=4 and N=8, sharing clock and controls.
module tb_mux4x1_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sel = 2'b00;

  logic [3:0] a0 = 4'b0101, a1 = 4'b0011, a2 = 4'b0100, a3 = 4'b1000;
  logic [7:0] b0 = 8'hA5, b1 = 8'h3C, b2 = 8'h81, b3 = 8'h7E;

  logic [3:0] out4;
  logic       vld4;
  logic [7:0] out8;
  logic       vld8;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp4 [4];
  logic [7:0] exp8 [4];

  always #5 clk = ~clk;

  mux4x1_param #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .in0(a0), .in1(a1), .in2(a2), .in3(a3),
    .out(out4), .out_vld(vld4)
  );

  mux4x1_param #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .in0(b0), .in1(b1), .in2(b2), .in3(b3),
    .out(out8), .out_vld(vld8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Sample just after the active edge.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp4[0] = 4'b0101; exp4[1] = 4'b0011; exp4[2] = 4'b0100; exp4[3] = 4'b1000;
    exp8[0] = 8'hA5;   exp8[1] = 8'h3C;   exp8[2] = 8'h81;   exp8[3] = 8'h7E;

    // Held reset ignores en/sel activity.
    @(negedge clk); en = 1'b1; sel = 2'b11;
    edge_sample();
    check("rst_hold_out4", 8'(out4), 8'h00);
    check("rst_hold_vld4", 8'(vld4), 8'h00);
    check("rst_hold_out8", out8, 8'h00);

    // Load something, then assert reset mid-cycle and see it clear at once.
    @(negedge clk); rst = 1'b0; en = 1'b1; sel = 2'b11;
    edge_sample();
    check("pre_rst_out4", 8'(out4), 8'(4'b1000));
    check("pre_rst_vld4", 8'(vld4), 8'h01);
    @(negedge clk); rst = 1'b1;
    #1;
    check("async_rst_out4", 8'(out4), 8'h00);
    check("async_rst_vld4", 8'(vld4), 8'h00);
    check("async_rst_out8", out8, 8'h00);
    @(negedge clk); rst = 1'b0; en = 1'b0;
    #1;
    check("post_rel_vld4", 8'(vld4), 8'h00);

    // Sweep, one select per cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); en = 1'b1; sel = 2'(i);
      edge_sample();
      check($sformatf("sweep4_sel%0d", i), 8'(out4), 8'(exp4[i]));
      check($sformatf("sweep8_sel%0d", i), out8, exp8[i]);
      check($sformatf("sweep_vld_sel%0d", i), 8'({vld8, vld4}), 8'h03);
    end

    // Hold with en low while sel moves.
    @(negedge clk); en = 1'b1; sel = 2'b01;
    edge_sample();
    check("hold_load4", 8'(out4), 8'(4'b0011));
    @(negedge clk); en = 1'b0; sel = 2'b11;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check($sformatf("hold4_c%0d", i), 8'(out4), 8'(4'b0011));
      check($sformatf("hold8_c%0d", i), out8, 8'h3C);
    end
    @(negedge clk); en = 1'b1;
    edge_sample();
    check("hold_release4", 8'(out4), 8'(4'b1000));

    // Data change on the selected input.
    @(negedge clk); sel = 2'b10; a2 = 4'b1111;
    edge_sample();
    check("data_change4", 8'(out4), 8'(4'b1111));
    a2 = 4'b0100;

    // Reset coinciding with a capture.
    @(negedge clk); en = 1'b1; sel = 2'b11; rst = 1'b1;
    edge_sample();
    check("overlap_out4", 8'(out4), 8'h00);
    check("overlap_vld4", 8'(vld4), 8'h00);
    @(negedge clk); rst = 1'b0;
    edge_sample();
    check("overlap_reload4", 8'(out4), 8'(4'b1000));
    check("overlap_reload8", out8, 8'h7E);
    check("overlap_vld4_set", 8'(vld4), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux4x1_param
